dmem_responder: RTL and testbench

Responder end of the MEM-stage data-memory interface. It accepts load/store requests driven by the MEM stage (MemRead, MemWrite, Address, Write_data), models a multi-cycle data RAM with a programmable wait-state count, and back-pressures the pipeline through Stall until each access completes. It replaces the single-cycle data memory behind the MEM stage. The hazard unit must freeze IF/ID/EX/MEM while Stall is high.

---
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Responder for the MEM-stage data-memory interface. It models a multi-cycle
// data RAM with WAIT_CYCLES wait states per access. Stall is held high until
// the access completes. The RAM is built from flops because reset must clear
// every word and reads are combinational in the completion cycle.
//
// Optional feature: define DMEM_MMIO_EN to add the LED register
// (0x4000_0000, R/W) and the free-running cycle counter (0x4000_0004,
// read-only). Both MMIO locations complete with zero wait states.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   MemRead    load request
//   MemWrite   store request (a store wins if both are high)
//   Address    byte address; bits [1:0] are ignored
//   Write_data store data
//   Read_data  load data in the completion cycle, 0 otherwise
//   Stall      access in progress; the pipeline must hold the request
//   AddrErr    pulses in the completion cycle of an out-of-range access
//   Leds       LED register (only with DMEM_MMIO_EN)
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        Stall,
  output logic        AddrErr
`ifdef DMEM_MMIO_EN
  ,
  output logic [7:0]  Leds
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // WAIT counts down the stall cycles that remain after the acceptance cycle
  // and the final cycle in WAIT. That is why it starts at W-2.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic            lat_write_reg;
  logic            lat_oor_reg;
  logic [AW-1:0]   lat_idx_reg;
  logic [31:0]     lat_data_reg;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            cur_oor;
  logic [AW-1:0]   cur_idx;
  logic            mmio_hit;
  logic [31:0]     mmio_rdata;
  logic            we;
  logic [AW-1:0]   widx;
  logic [31:0]     wdata;
  logic            unused_addr_bits;

  assign req              = MemRead | MemWrite;
  assign cur_oor          = Address[31:2] >= 30'(DEPTH);
  assign cur_idx          = Address[AW+1:2];
  assign unused_addr_bits = ^Address[1:0];

`ifdef DMEM_MMIO_EN
  logic [7:0]  leds_reg;
  logic [31:0] cycle_reg;
  logic        hit_leds;
  logic        hit_cycle;

  assign hit_leds   = Address[31:2] == 30'h1000_0000;
  assign hit_cycle  = Address[31:2] == 30'h1000_0001;
  assign mmio_hit   = (state_reg == S_IDLE) && (hit_leds || hit_cycle);
  assign mmio_rdata = hit_leds ? {24'd0, leds_reg} : cycle_reg;
  assign Leds       = leds_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_reg  <= '0;
      cycle_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      // Only the LED register is writable. Stores to the counter are ignored.
      if (mmio_hit && MemWrite && hit_leds)
        leds_reg <= Write_data[7:0];
    end
  end
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = '0;
`endif

  // Access sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      lat_write_reg <= 1'b0;
      lat_oor_reg   <= 1'b0;
      lat_idx_reg   <= '0;
      lat_data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req && !mmio_hit && WAIT_CYCLES != 0) begin
            lat_write_reg <= MemWrite;
            lat_oor_reg   <= cur_oor;
            lat_idx_reg   <= cur_idx;
            lat_data_reg  <= Write_data;
            cnt_reg       <= CNT_INIT;
            state_reg     <= (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req)
            state_reg <= S_IDLE;            // flush: abandon the access
          else if (cnt_reg == 4'd0)
            state_reg <= S_DONE;
          else
            cnt_reg <= cnt_reg - 4'd1;
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // RAM write port. Zero-wait stores commit directly from the inputs. All
  // other stores commit from the latched copy at the end of DONE.
  always_comb begin
    we    = 1'b0;
    widx  = cur_idx;
    wdata = Write_data;
    if (state_reg == S_IDLE) begin
      if (WAIT_CYCLES == 0 && MemWrite && !cur_oor && !mmio_hit)
        we = 1'b1;
    end else if (state_reg == S_DONE && req && lat_write_reg && !lat_oor_reg) begin
      we    = 1'b1;
      widx  = lat_idx_reg;
      wdata = lat_data_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Outputs are combinational and are forced low while reset is held.
  // This makes Stall drop immediately when an access is aborted by reset.
  always_comb begin
    Stall     = 1'b0;
    Read_data = '0;
    AddrErr   = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            if (mmio_hit) begin
              if (!MemWrite)
                Read_data = mmio_rdata;
            end else if (WAIT_CYCLES == 0) begin
              if (cur_oor)
                AddrErr = 1'b1;
              else if (!MemWrite)
                Read_data = mem[cur_idx];
            end else begin
              Stall = 1'b1;
            end
          end
        end
        S_WAIT: Stall = req;
        S_DONE: begin
          if (req) begin
            if (lat_oor_reg)
              AddrErr = 1'b1;
            else if (!lat_write_reg)
              Read_data = mem[lat_idx_reg];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int W     = 3;

  logic        clk = 1'b0;
  logic        reset;
  // Multi-cycle instance (W=3)
  logic        mr, mw, st, ae;
  logic [31:0] addr, wd, rd;
  // Zero-wait instance (W=0)
  logic        mr0, mw0, st0, ae0;
  logic [31:0] addr0, wd0, rd0;
`ifdef DMEM_MMIO_EN
  logic [7:0]  leds, leds0;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model  [DEPTH];
  logic [31:0] model0 [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .MemRead(mr), .MemWrite(mw), .Address(addr),
    .Write_data(wd), .Read_data(rd), .Stall(st), .AddrErr(ae)
`ifdef DMEM_MMIO_EN
    , .Leds(leds)
`endif
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(mr0), .MemWrite(mw0), .Address(addr0),
    .Write_data(wd0), .Read_data(rd0), .Stall(st0), .AddrErr(ae0)
`ifdef DMEM_MMIO_EN
    , .Leds(leds0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the W=3 instance. It checks every cycle from acceptance to
  // completion. flush_at > 0 drops the request in that cycle instead.
  task automatic access3(input bit rd_op, input bit wr_op, input logic [31:0] a,
                         input logic [31:0] d, input int flush_at);
    bit          inr;
    logic [31:0] exp_rd;
    int          idx;
    int          r;
    mr = rd_op; mw = wr_op; addr = a; wd = d;
    inr    = a[31:2] < 30'(DEPTH);
    idx    = inr ? int'(a[31:2]) : 0;
    exp_rd = (!wr_op && inr) ? model[idx] : 32'd0;
    for (int c = 0; c <= W; c++) begin
      if (c == flush_at) begin
        mr = 1'b0; mw = 1'b0;
        @(negedge clk);
        check("flush_aerr", ae, 0);
        tick();
        @(negedge clk);
        check("flush_stall", st, 0);
        check("flush_rdata", rd, 0);
        check("flush_aerr_next", ae, 0);
        tick();
        return;
      end
      if (c > 0) begin
        // The responder must ignore input changes after acceptance.
        r = $urandom_range(0, 2);
        mr = (r != 1); mw = (r != 0);
        addr = $urandom; wd = $urandom;
      end
      @(negedge clk);
      if (c < W) begin
        check("stall_busy", st, 1);
        check("rdata_busy", rd, 0);
        check("aerr_busy", ae, 0);
      end else begin
        check("stall_done", st, 0);
        check("rdata_done", rd, exp_rd);
        check("aerr_done", ae, {31'd0, !inr});
      end
      tick();
    end
    if (wr_op && inr) model[idx] = d;
  endtask

  task automatic idle3(input int n);
    mr = 1'b0; mw = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_stall", st, 0);
      check("idle_rdata", rd, 0);
      tick();
    end
  endtask

  // One cycle on the W=0 instance. Completion occurs in the same cycle.
  task automatic access0(input bit rd_op, input bit wr_op, input logic [31:0] a,
                         input logic [31:0] d);
    bit inr;
    int idx;
    mr0 = rd_op; mw0 = wr_op; addr0 = a; wd0 = d;
    inr = a[31:2] < 30'(DEPTH);
    idx = inr ? int'(a[31:2]) : 0;
    @(negedge clk);
    check("w0_stall", st0, 0);
    check("w0_rdata", rd0, ((rd_op || wr_op) && !wr_op && inr) ? model0[idx] : 32'd0);
    check("w0_aerr", ae0, {31'd0, (rd_op || wr_op) && !inr});
    tick();
    if (wr_op && inr) model0[idx] = d;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0)
      return (32'($urandom_range(DEPTH, 4000)) << 2) | 32'($urandom_range(0, 3));
    return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [31:0] c1, c2;
    for (int i = 0; i < DEPTH; i++) begin model[i] = '0; model0[i] = '0; end
    reset = 1'b1;
    mr = 0; mw = 0; addr = 0; wd = 0;
    mr0 = 0; mw0 = 0; addr0 = 0; wd0 = 0;
    #1;
    check("rst_stall", st, 0);
    check("rst_rdata", rd, 0);
    check("rst_aerr", ae, 0);
`ifdef DMEM_MMIO_EN
    check("rst_leds", leds, 0);
`endif
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    tick();

    // Store 0xDEADBEEF to 0x10, then load it back.
    access3(0, 1, 32'h10, 32'hDEADBEEF, -1);
    access3(1, 0, 32'h10, 32'h0, -1);
    // Out-of-range store aliases to index 0 if the range check is broken.
    access3(0, 1, 32'h400, 32'h12345678, -1);
    access3(1, 0, 32'h0, 32'h0, -1);
    // A flushed store leaves the old value in place.
    access3(0, 1, 32'h20, 32'hCAFEF00D, 1);
    access3(1, 0, 32'h20, 32'h0, -1);
    // Both requests are high, so the access is a store and reads back 0.
    access3(1, 1, 32'h24, 32'h55AA55AA, -1);
    access3(1, 0, 32'h24, 32'h0, -1);

    // Randomized accesses, back to back or with gaps, with occasional flushes.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 2);
      access3(r != 1, r != 0, rand_addr(), $urandom,
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W)) : -1);
      idle3($urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a store discards it and clears the RAM.
    mr = 0; mw = 1; addr = 32'h30; wd = 32'hA5A5A5A5;
    tick(); tick();
    #2 reset = 1'b1;
    #1 check("async_rst_stall", st, 0);
    mw = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    tick();
    access3(1, 0, 32'h30, 32'h0, -1);
    access3(1, 0, 32'h10, 32'h0, -1);

    // Zero-wait instance: back-to-back loads after reset, then random traffic.
    for (int i = 0; i < 8; i++) access0(1, 0, 32'(i * 4), 32'h0);
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 3);
      access0(r == 0 || r == 2, r == 1 || r == 2, rand_addr(), $urandom);
    end
    access0(0, 0, 32'h0, 32'h0);

`ifdef DMEM_MMIO_EN
    // LED store, LED load and two counter reads 5 cycles apart. All of them
    // complete with zero wait states.
    mr = 0; mw = 1; addr = 32'h4000_0000; wd = 32'h1A5;
    @(negedge clk);
    check("mmio_st_stall", st, 0);
    check("mmio_st_aerr", ae, 0);
    tick();
    check("mmio_leds", leds, 8'hA5);
    mr = 1; mw = 0;
    @(negedge clk);
    check("mmio_led_read", rd, 32'hA5);
    tick();
    addr = 32'h4000_0004;
    @(negedge clk);
    check("mmio_cnt_stall", st, 0);
    c1 = rd;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    c2 = rd;
    check("mmio_cnt_delta", c2 - c1, 32'd5);
    tick();
    mr = 0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
